pe_mem_responder: RTL
=====================

Name: pe_mem_responder

Overview:
Memory-side responder for the PE controller's load handshake (mem_read / mem_address / mem_ack / mem_Message). It holds a word-organised data RAM. It accepts one read request at a time and returns the addressed word with a single-cycle mem_ack after a programmable latency. It sits between the PE and the CGRA data memory, and serves as the memory model in PE-level benches.

Parameters:
DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (default 1024 words)
LATENCY, 2, cycles from request acceptance to mem_ack; legal range 1..15
INIT_VALUE, 32'h0, value returned for out-of-range reads

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
mem_read  input  1  load request from PE controller, level
mem_address  input  32  byte address of request
mem_ack  output  1  one-cycle response strobe
mem_Message  output  32  read data, valid while mem_ack=1
mem_err  output  1  high with mem_ack when address is out of range
init_we  input  1  preload write strobe (loader/bench)
init_addr  input  DEPTH_LOG2  preload word index
init_data  input  32  preload word
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, mem_ack=0, mem_Message=0, mem_err=0, busy=0, latency counter=0. RAM contents are not cleared.
- Reset mid-operation: any pending request is dropped with no ack. The controller must re-request.
- Word index = mem_address[DEPTH_LOG2+1:2]. Bits [1:0] are ignored; the containing word is returned, and byte/half extraction is done by the PE ALU.
- Out of range: any of mem_address[31:DEPTH_LOG2+2] is nonzero. Response is mem_Message=INIT_VALUE with mem_err=1.
- FSM states:
  - IDLE: mem_read=1 at edge k -> latch address, load counter with LATENCY-1, go to WAIT.
  - WAIT: counter decrements each edge. On the edge where the counter is 0, drive mem_ack=1 with the RAM/err data read at that edge, and go to ACK.
  - ACK: mem_ack=1 for exactly one cycle. At the next edge mem_ack returns to 0. If mem_read=0, go to IDLE; else go to DROP.
  - DROP: wait until mem_read=0, then go to IDLE. Prevents a second response to a level-held request.
- Latency: mem_ack goes high at edge k+LATENCY. With LATENCY=1 this is the edge after acceptance.
- mem_address changes after acceptance are ignored; the latched address is used.
- mem_Message holds its last value after mem_ack falls. It updates only on an ack edge.
- Preload: init_we writes RAM[init_addr]=init_data at the edge in any state.
- Same-edge preload write and response read of the same word: the response returns the old data (read-before-write).
- mem_read=1 during rst is ignored. The request is accepted on the first non-reset edge at which it is still high.

Optional Feature:
MEM_WRITE_EN
- With the macro: adds ports mem_write (in, 1), mem_wdata (in, 32) and mem_wstrb (in, 4).
- A request with mem_write=1 is accepted in IDLE like a read, and follows the same LATENCY/ACK/DROP flow.
- At the ack edge, bytes with mem_wstrb[i]=1 of the in-range word are written.
- mem_Message returns the pre-write word.
- Out-of-range writes are discarded and flagged with mem_err=1.
- mem_read=1 and mem_write=1 together: the write takes precedence.
- Preload-vs-response conflict on the same word: the response write wins.
- Without the macro: ports are absent and the block is read-only apart from preload.

Decomposition:
- Package pe_mem_pkg: WORD_W=32, a state enum {IDLE, WAIT, ACK, DROP} (2 bits), a LAT_W=4 counter width constant, and an out-of-range check function.
- Sub-module pe_data_ram holds the storage:
  - synchronous single-port RAM plus the preload port;
  - byte-write enables, used only when MEM_WRITE_EN is defined;
  - read-before-write behaviour.

Test Plan:
- Preload RAM[5]=32'hDEADBEEF; pulse mem_read with mem_address=0x14, LATENCY=2 -> mem_ack=1 exactly at edge k+2 for one cycle, mem_Message=32'hDEADBEEF, mem_err=0.
- Hold mem_read=1 for 6 cycles, address 0x16 -> one ack with RAM[5] data, FSM stays in DROP until mem_read falls, no second ack.
- mem_address=0x0000_1000 with DEPTH_LOG2=10 -> mem_ack=1, mem_err=1, mem_Message=INIT_VALUE.
- Assert rst in the WAIT state -> mem_ack never asserts, busy=0 next cycle; re-request -> normal response after LATENCY.
- Same-edge init_we to word 5 with 32'h1 and ack on word 5 -> mem_Message = old value; a following read returns 32'h1.
- MEM_WRITE_EN: write 32'hAABBCCDD to 0x20 with wstrb=4'b0011 over initial 0 -> ack with mem_Message=0; a subsequent read returns 32'h0000CCDD.

Source files
------------

// File: rtl/pe_mem_pkg.sv
// pe_mem_pkg: shared types and helpers for the PE memory responder.
//   WORD_W            - data word width (bits)
//   LAT_W             - latency counter width (covers 1..15 cycles)
//   state_e           - responder FSM state encoding
//   addr_out_of_range - true when any address bit above the RAM word index is set
package pe_mem_pkg;

    localparam int WORD_W = 32;
    localparam int LAT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        DROP = 2'd3
    } state_e;

    // Byte address -> word index uses bits [depth_log2+1:2]; anything above is out of range.
    function automatic logic addr_out_of_range(input logic [WORD_W-1:0] addr,
                                               input int unsigned depth_log2);
        return (addr >> (depth_log2 + 2)) != '0;
    endfunction

endpackage

// File: rtl/pe_mem_responder_if.sv
// pe_mem_responder_if: PE load handshake bundle.
//   mem_read, mem_address        - request from the PE controller (master drives)
//   mem_ack, mem_Message, mem_err - response from the memory (slave drives)
//   mem_write, mem_wdata, mem_wstrb - store request, only with MEM_WRITE_EN defined
interface pe_mem_responder_if;

    logic                          mem_read;
    logic [pe_mem_pkg::WORD_W-1:0] mem_address;
    logic                          mem_ack;
    logic [pe_mem_pkg::WORD_W-1:0] mem_Message;
    logic                          mem_err;
`ifdef MEM_WRITE_EN
    logic                          mem_write;
    logic [pe_mem_pkg::WORD_W-1:0] mem_wdata;
    logic [3:0]                    mem_wstrb;

    modport master (output mem_read, mem_address, mem_write, mem_wdata, mem_wstrb,
                    input  mem_ack, mem_Message, mem_err);
    modport slave  (input  mem_read, mem_address, mem_write, mem_wdata, mem_wstrb,
                    output mem_ack, mem_Message, mem_err);
`else
    modport master (output mem_read, mem_address,
                    input  mem_ack, mem_Message, mem_err);
    modport slave  (input  mem_read, mem_address,
                    output mem_ack, mem_Message, mem_err);
`endif

endinterface

// File: rtl/pe_data_ram.sv
// pe_data_ram: word-organised data RAM with a registered read port and a preload port.
// Optional macro MEM_WRITE_EN adds a byte-strobed write on the response port.
//   clk, rst    - clock; rst clears only the read data register, never the array
//   rd_en, addr - read strobe and word index; rdata updates on an rd_en edge, else holds
//   wr_en, wstrb, wdata - byte write at addr (MEM_WRITE_EN only)
//   init_we, init_addr, init_data - preload write, any time
// Reads return the pre-edge contents (read-before-write). When a preload and a
// response write hit the same word on one edge, the response write lands last.
module pe_data_ram
    import pe_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] addr,
    output logic [WORD_W-1:0]     rdata,
`ifdef MEM_WRITE_EN
    input  logic                  wr_en,
    input  logic [3:0]            wstrb,
    input  logic [WORD_W-1:0]     wdata,
`endif
    input  logic                  init_we,
    input  logic [DEPTH_LOG2-1:0] init_addr,
    input  logic [WORD_W-1:0]     init_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WORD_W-1:0] ram_mem [0:DEPTH-1];
    logic [WORD_W-1:0] rdata_d, rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) rdata_d = ram_mem[addr];
    end

    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    always_ff @(posedge clk) begin
        if (init_we) ram_mem[init_addr] <= init_data;
`ifdef MEM_WRITE_EN
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) ram_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
`endif
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pe_mem_responder.sv
// pe_mem_responder: memory-side responder for the PE load handshake.
// Accepts one request at a time, answers with a one-cycle mem_ack LATENCY edges
// after acceptance. Optional macro MEM_WRITE_EN enables byte-strobed stores.
//   clk, rst  - clock, synchronous active-high reset
//   bus       - slave side of pe_mem_responder_if (request in, ack/data/err out)
//   init_we, init_addr, init_data - RAM preload port
//   busy      - high whenever the FSM is not in IDLE
//
//   state | meaning
//   IDLE  | waiting for a request
//   WAIT  | request latched, latency counter running down
//   ACK   | mem_ack high for this one cycle
//   DROP  | request still held after ack; wait for it to fall
module pe_mem_responder
    import pe_mem_pkg::*;
#(
    parameter int                DEPTH_LOG2 = 10,
    parameter int                LATENCY    = 2,
    parameter logic [WORD_W-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    pe_mem_responder_if.slave     bus,
    input  logic                  init_we,
    input  logic [DEPTH_LOG2-1:0] init_addr,
    input  logic [WORD_W-1:0]     init_data,
    output logic                  busy
);

    state_e            state_d, state_q;
    logic [LAT_W-1:0]  cnt_d, cnt_q;
    logic [WORD_W-1:0] addr_d, addr_q;
    logic              ack_d, ack_q;
    logic              err_d, err_q;
    logic              req;
    logic              oor;
    logic              rd_en;
    logic [WORD_W-1:0] ram_rdata;

`ifdef MEM_WRITE_EN
    logic              wr_d, wr_q;
    logic [WORD_W-1:0] wdata_d, wdata_q;
    logic [3:0]        wstrb_d, wstrb_q;
    assign req = bus.mem_read | bus.mem_write;
`else
    assign req = bus.mem_read;
`endif

    assign oor = addr_out_of_range(addr_q, DEPTH_LOG2);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        ack_d   = 1'b0;
        err_d   = err_q;
        rd_en   = 1'b0;
`ifdef MEM_WRITE_EN
        wr_d    = wr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = bus.mem_address;
                    cnt_d   = LAT_W'(LATENCY - 1);
                    state_d = WAIT;
`ifdef MEM_WRITE_EN
                    wr_d    = bus.mem_write;
                    wdata_d = bus.mem_wdata;
                    wstrb_d = bus.mem_wstrb;
`endif
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    ack_d   = 1'b1;
                    err_d   = oor;
                    // Out-of-range responses never touch the RAM; data is masked to INIT_VALUE.
                    rd_en   = ~oor;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            ACK:     state_d = req ? DROP : IDLE;
            DROP:    if (!req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef MEM_WRITE_EN
            wr_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
`ifdef MEM_WRITE_EN
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
`endif
        end
    end

    pe_data_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .addr      (addr_q[DEPTH_LOG2+1:2]),
        .rdata     (ram_rdata),
`ifdef MEM_WRITE_EN
        .wr_en     (rd_en & wr_q),
        .wstrb     (wstrb_q),
        .wdata     (wdata_q),
`endif
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    // err_q and the RAM read register both hold between acks, so the message holds too.
    assign bus.mem_ack     = ack_q;
    assign bus.mem_err     = err_q;
    assign bus.mem_Message = err_q ? INIT_VALUE : ram_rdata;
    assign busy            = (state_q != IDLE);

endmodule
